// File: rtl/host_mem_rd_credit_limiter.sv
// Kernel-side read credit limiter for the host-memory Avalon read channel.
// Holds one command, issues it only while in-flight beats stay within MAX_OUTSTANDING, and registers responses.
module host_mem_rd_credit_limiter #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 6,
  parameter int MAX_OUTSTANDING = 256,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       pClk,
  input  logic                       pClk_reset,
  input  logic [ADDR_WIDTH-1:0]      k_address,
  input  logic                       k_read,
  input  logic [BURST_CNT_WIDTH-1:0] k_burstcount,
  output logic                       k_waitrequest,
  output logic [DATA_WIDTH-1:0]      k_readdata,
  output logic                       k_readdatavalid,
  output logic [ADDR_WIDTH-1:0]      h_address,
  output logic                       h_read,
  output logic [BURST_CNT_WIDTH-1:0] h_burstcount,
  input  logic                       h_waitrequest,
  input  logic [DATA_WIDTH-1:0]      h_readdata,
  input  logic                       h_readdatavalid,
  output logic [CNT_WIDTH-1:0]       outstanding_beats,
  output logic [31:0]                credit_stall_cnt,
  output logic                       err_sticky
);

  localparam int SUM_WIDTH = CNT_WIDTH + 1;
  localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST = BURST_CNT_WIDTH'(2 ** (BURST_CNT_WIDTH - 1));

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } cmd_state_t;

  cmd_state_t                 state;
  cmd_state_t                 state_next;
  logic [ADDR_WIDTH-1:0]      cmd_addr;
  logic [BURST_CNT_WIDTH-1:0] cmd_burst;
  logic                       cmd_valid;
  logic                       credit_ok;
  logic                       issue;
  logic                       accept;
  logic                       burst_legal;
  logic                       load_cmd;
  logic                       underflow;
  logic [SUM_WIDTH-1:0]       credit_sum;
  logic [CNT_WIDTH-1:0]       count_next;

  assign cmd_valid     = (state == HOLD);
  assign credit_sum    = SUM_WIDTH'(outstanding_beats) + SUM_WIDTH'(cmd_burst);
  assign credit_ok     = (credit_sum <= SUM_WIDTH'(MAX_OUTSTANDING));
  assign h_read        = cmd_valid && credit_ok;
  assign h_address     = cmd_addr;
  assign h_burstcount  = cmd_burst;
  assign issue         = h_read && !h_waitrequest;
  // Freeing the holding stage in the issue cycle lets the next command in without a bubble.
  assign k_waitrequest = pClk_reset || (cmd_valid && !issue);
  assign accept        = k_read && !k_waitrequest;
  assign burst_legal   = (k_burstcount != '0) && (k_burstcount <= MAX_BURST);
  assign load_cmd      = accept && burst_legal;

  // Holding-stage next state; illegal bursts are swallowed without touching the stage.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (load_cmd) begin
          state_next = HOLD;
        end else begin
          state_next = EMPTY;
        end
      end
      HOLD: begin
        if (load_cmd) begin
          state_next = HOLD;
        end else if (issue) begin
          state_next = EMPTY;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Occupancy update; issue only happens with credit, so the sum never exceeds MAX_OUTSTANDING.
  always_comb begin
    underflow  = 1'b0;
    count_next = outstanding_beats;
    if (issue) begin
      count_next = count_next + CNT_WIDTH'(cmd_burst);
    end else begin
      count_next = outstanding_beats;
    end
    if (h_readdatavalid) begin
      if (count_next == '0) begin
        underflow = 1'b1;
      end else begin
        count_next = count_next - CNT_WIDTH'(1);
      end
    end else begin
      underflow = 1'b0;
    end
  end

  // Command stage registers.
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      state     <= EMPTY;
      cmd_addr  <= '0;
      cmd_burst <= '0;
    end else begin
      state <= state_next;
      if (load_cmd) begin
        cmd_addr  <= k_address;
        cmd_burst <= k_burstcount;
      end
    end
  end

  // Occupancy, stall statistics and sticky error.
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      outstanding_beats <= '0;
      credit_stall_cnt  <= 32'd0;
      err_sticky        <= 1'b0;
    end else begin
      outstanding_beats <= count_next;
      if (cmd_valid && !credit_ok && (credit_stall_cnt != 32'hFFFF_FFFF)) begin
        credit_stall_cnt <= credit_stall_cnt + 32'd1;
      end
      if ((accept && !burst_legal) || underflow) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Response path: one register stage, never back-pressured.
  always_ff @(posedge pClk) begin
    if (pClk_reset) begin
      k_readdatavalid <= 1'b0;
      k_readdata      <= '0;
    end else begin
      k_readdatavalid <= h_readdatavalid;
      k_readdata      <= h_readdata;
    end
  end

endmodule
